// File: rtl/zx_io_pkg.sv
// Shared field positions and interrupt FSM state type for the ZX I/O controller.
// Pure declarations; no logic, no latency, no flow control.
// Used by zx_io_ctrl and zx_int_gen.
package zx_io_pkg;

    localparam int ULA_BORDER_LSB = 0;
    localparam int ULA_BORDER_W   = 3;
    localparam int ULA_MIC_BIT    = 3;
    localparam int ULA_BEEPER_BIT = 4;

    localparam int PG_PAGE_LSB = 0;
    localparam int PG_PAGE_W   = 3;
    localparam int PG_SCR_BIT  = 4'd3;
    localparam int PG_ROM_BIT  = 4;
    localparam int PG_LOCK_BIT = 5;

    localparam int KBD_ROWS = 8;
    localparam int KBD_COLS = 5;

    typedef enum logic {
        INT_IDLE   = 1'b0,
        INT_ASSERT = 1'b1
    } int_state_t;

endpackage

// File: rtl/zx_int_gen.sv
// Frame interrupt generator: vsync rising edge holds n_int low for INT_LEN clk or until ack.
// Latency: n_int falls one clk after the edge and rises one clk after timeout/ack.
// No backpressure; edges arriving while asserted are dropped.
module zx_int_gen
    import zx_io_pkg::*;
#(
    parameter int INT_LEN   = 32,
    parameter int INT_CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    input  logic ack,
    output logic n_int
);

    localparam logic [INT_CNT_W-1:0] CNT_LOAD = INT_CNT_W'(INT_LEN - 1);

    int_state_t            state;
    int_state_t            state_nxt;
    logic [INT_CNT_W-1:0]  cnt;
    logic [INT_CNT_W-1:0]  cnt_nxt;
    logic                  vsync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INT_IDLE;
            cnt     <= '0;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            vsync_q <= vsync_in;
        end
    end

    // Edges seen in ASSERT (including its final cycle) are not remembered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            INT_IDLE: begin
                if (vsync_in && !vsync_q) begin
                    state_nxt = INT_ASSERT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            INT_ASSERT: begin
                if ((cnt == '0) || ack) begin
                    state_nxt = INT_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - INT_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = INT_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign n_int = (state != INT_ASSERT);

endmodule

// File: rtl/zx_io_ctrl.sv
// ZX Spectrum style I/O: ULA port FE (border/mic/beeper, keyboard/ear read), frame interrupt, optional 7FFD paging (ZX_PAGING_EN).
// Latency: port writes visible 1 clk after the registered strobe edge; reads are combinational.
// No backpressure; one register update per write strobe regardless of its length.
module zx_io_ctrl
    import zx_io_pkg::*;
#(
    parameter int INT_LEN   = 32,
    parameter int INT_CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [7:0]  d_in,
    input  logic        n_iorq,
    input  logic        n_rd,
    input  logic        n_wr,
    input  logic        n_m1,
    input  logic        vsync_in,
    input  logic [39:0] kbd,
    input  logic        ear_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic [2:0]  border,
    output logic        beeper,
    output logic        mic,
    output logic        n_int,
    output logic [2:0]  ram_page,
    output logic        scr_sel,
    output logic        rom_sel,
    output logic        pg_lock
);

    logic iorq_q;
    logic rd_q;
    logic wr_q;
    logic m1_q;
    logic sampled;
    logic wr_hist;
    logic wr_n_now;
    logic wr_stb;
    logic ack;
    logic [KBD_COLS-1:0] k;
    logic unused_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iorq_q  <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            m1_q    <= 1'b1;
            sampled <= 1'b0;
            wr_hist <= 1'b1;
        end else begin
            iorq_q  <= n_iorq;
            rd_q    <= n_rd;
            wr_q    <= n_wr;
            m1_q    <= n_m1;
            sampled <= 1'b1;
            // Until the bus has really been sampled, treat the strobe as already
            // active so one held through reset release never looks like a new edge.
            wr_hist <= sampled ? wr_n_now : 1'b0;
        end
    end

    assign wr_n_now = iorq_q | wr_q;
    assign wr_stb   = wr_hist & ~wr_n_now & m1_q;
    assign ack      = ~m1_q & ~iorq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            border <= '0;
            mic    <= 1'b0;
            beeper <= 1'b0;
        end else if (wr_stb && !a[0]) begin
            border <= d_in[ULA_BORDER_LSB +: ULA_BORDER_W];
            mic    <= d_in[ULA_MIC_BIT];
            beeper <= d_in[ULA_BEEPER_BIT];
        end
    end

    always_comb begin
        k = '1;
        for (int r = 0; r < KBD_ROWS; r++) begin
            if (!a[8 + r]) begin
                k = k & kbd[KBD_COLS * r +: KBD_COLS];
            end
        end
    end

    assign d_oe  = ~n_iorq & ~n_rd & n_m1 & ~a[0];
    assign d_out = d_oe ? {1'b1, ear_in, 1'b1, k} : 8'hFF;

`ifdef ZX_PAGING_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_page <= '0;
            scr_sel  <= 1'b0;
            rom_sel  <= 1'b0;
            pg_lock  <= 1'b0;
        end else if (wr_stb && !a[15] && !a[1] && a[0] && !pg_lock) begin
            ram_page <= d_in[PG_PAGE_LSB +: PG_PAGE_W];
            scr_sel  <= d_in[PG_SCR_BIT];
            rom_sel  <= d_in[PG_ROM_BIT];
            pg_lock  <= d_in[PG_LOCK_BIT];
        end
    end

    assign unused_bits = ^{rd_q, a[7:2], d_in[7:6]};
`else
    assign ram_page = '0;
    assign scr_sel  = 1'b0;
    assign rom_sel  = 1'b0;
    assign pg_lock  = 1'b0;

    assign unused_bits = ^{rd_q, a[15], a[7:1], d_in[7:5]};
`endif

    zx_int_gen #(
        .INT_LEN   (INT_LEN),
        .INT_CNT_W (INT_CNT_W)
    ) u_int_gen (
        .clk      (clk),
        .reset    (reset),
        .vsync_in (vsync_in),
        .ack      (ack),
        .n_int    (n_int)
    );

endmodule

// File: tb/tb_zx_io_ctrl.sv
// Directed bench for zx_io_ctrl; paging checks follow ZX_PAGING_EN.
module tb_zx_io_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic        n_iorq;
    logic        n_rd;
    logic        n_wr;
    logic        n_m1;
    logic        vsync_in;
    logic [39:0] kbd;
    logic        ear_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [2:0]  border;
    logic        beeper;
    logic        mic;
    logic        n_int;
    logic [2:0]  ram_page;
    logic        scr_sel;
    logic        rom_sel;
    logic        pg_lock;

    int errors;
    int checks;
    int low_cnt;
    logic first_nint;

    zx_io_ctrl #(
        .INT_LEN   (32),
        .INT_CNT_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .d_in     (d_in),
        .n_iorq   (n_iorq),
        .n_rd     (n_rd),
        .n_wr     (n_wr),
        .n_m1     (n_m1),
        .vsync_in (vsync_in),
        .kbd      (kbd),
        .ear_in   (ear_in),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .border   (border),
        .beeper   (beeper),
        .mic      (mic),
        .n_int    (n_int),
        .ram_page (ram_page),
        .scr_sel  (scr_sel),
        .rom_sel  (rom_sel),
        .pg_lock  (pg_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
        a      = addr;
        d_in   = data;
        n_iorq = 1'b0;
        n_wr   = 1'b0;
        tick(hold);
        n_iorq = 1'b1;
        n_wr   = 1'b1;
        tick(2);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        a        = 16'hFFFF;
        d_in     = 8'h00;
        n_iorq   = 1'b1;
        n_rd     = 1'b1;
        n_wr     = 1'b1;
        n_m1     = 1'b1;
        vsync_in = 1'b0;
        kbd      = '1;
        ear_in   = 1'b0;

        #3;
        chk("rst_border", 16'(border), 16'h0);
        chk("rst_beeper", 16'(beeper), 16'h0);
        chk("rst_mic", 16'(mic), 16'h0);
        chk("rst_nint", 16'(n_int), 16'h1);
        chk("rst_page", 16'({ram_page, scr_sel, rom_sel, pg_lock}), 16'h0);
        chk("rst_doe", 16'(d_oe), 16'h0);
        chk("rst_dout", 16'(d_out), 16'h00FF);

        tick(2);
        reset = 1'b0;
        tick(2);

        // OUT (FE),15 held 10 clk; data changes mid-strobe must not be taken
        a      = 16'h00FE;
        d_in   = 8'h15;
        n_iorq = 1'b0;
        n_wr   = 1'b0;
        tick(1);
        chk("ula_latency", 16'(border), 16'h0);
        tick(1);
        chk("ula_border", 16'(border), 16'h5);
        chk("ula_mic", 16'(mic), 16'h0);
        chk("ula_beeper", 16'(beeper), 16'h1);
        d_in = 8'h07;
        tick(8);
        chk("ula_one_update", 16'(border), 16'h5);
        n_iorq = 1'b1;
        n_wr   = 1'b1;
        tick(2);
        chk("ula_after_release", 16'({border, mic, beeper}), 16'({3'b101, 1'b0, 1'b1}));

        io_write(16'h00FE, 8'h08, 1);
        chk("ula_short_strobe", 16'({border, mic, beeper}), 16'({3'b000, 1'b1, 1'b0}));

        n_m1 = 1'b0;
        io_write(16'h00FE, 8'h17, 3);
        n_m1 = 1'b1;
        tick(1);
        chk("ula_m1_ignored", 16'({border, mic, beeper}), 16'({3'b000, 1'b1, 1'b0}));

        io_write(16'h00FE, 8'h0A, 2);
        chk("ula_border2", 16'({border, mic, beeper}), 16'({3'b010, 1'b1, 1'b0}));

        // keyboard reads
        kbd    = '1;
        kbd[0] = 1'b0;
        a      = 16'hFEFE;
        n_iorq = 1'b0;
        n_rd   = 1'b0;
        #1;
        chk("rd_row0", 16'(d_out), 16'h00BE);
        chk("rd_doe", 16'(d_oe), 16'h1);
        a = 16'hFFFE;
        #1;
        chk("rd_no_row", 16'(d_out), 16'h00BF);
        ear_in = 1'b1;
        a      = 16'hFEFE;
        #1;
        chk("rd_ear", 16'(d_out), 16'h00FE);
        ear_in = 1'b0;
        kbd[7] = 1'b0;
        a      = 16'hFCFE;
        #1;
        chk("rd_two_rows", 16'(d_out), 16'h00BA);
        a = 16'hFCFF;
        #1;
        chk("rd_odd_doe", 16'(d_oe), 16'h0);
        chk("rd_odd_dout", 16'(d_out), 16'h00FF);
        a    = 16'hFEFE;
        n_m1 = 1'b0;
        #1;
        chk("rd_m1_doe", 16'(d_oe), 16'h0);
        n_m1   = 1'b1;
        n_iorq = 1'b1;
        n_rd   = 1'b1;
        #1;
        chk("rd_idle_doe", 16'(d_oe), 16'h0);
        kbd = '1;
        tick(2);

        // interrupt length with a second edge part-way through
        vsync_in   = 1'b1;
        low_cnt    = 0;
        first_nint = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (i == 0) first_nint = n_int;
            if (i == 5) vsync_in = 1'b0;
            if (i == 10) vsync_in = 1'b1;
            if (n_int == 1'b0) low_cnt++;
        end
        chk("int_first", 16'(first_nint), 16'h0);
        chk("int_len", 16'(low_cnt), 16'd32);
        chk("int_end", 16'(n_int), 16'h1);

        // acknowledge at clk 5 releases n_int at clk 7
        vsync_in = 1'b0;
        tick(2);
        vsync_in = 1'b1;
        tick(5);
        chk("ack_pre", 16'(n_int), 16'h0);
        n_m1   = 1'b0;
        n_iorq = 1'b0;
        tick(1);
        chk("ack_clk6", 16'(n_int), 16'h0);
        tick(1);
        chk("ack_clk7", 16'(n_int), 16'h1);
        n_m1   = 1'b1;
        n_iorq = 1'b1;
        tick(4);
        chk("ack_no_retrig", 16'(n_int), 16'h1);

        // 7FFD paging
        io_write(16'h7FFD, 8'h27, 2);
`ifdef ZX_PAGING_EN
        chk("pg_page", 16'(ram_page), 16'h7);
        chk("pg_sel", 16'({scr_sel, rom_sel}), 16'h0);
        chk("pg_lock", 16'(pg_lock), 16'h1);
        io_write(16'h7FFD, 8'h01, 2);
        chk("pg_locked", 16'({ram_page, pg_lock}), 16'({3'd7, 1'b1}));
`else
        chk("pg_off", 16'({ram_page, scr_sel, rom_sel, pg_lock}), 16'h0);
`endif
        chk("pg_border_kept", 16'(border), 16'h2);

        // reset mid-interrupt
        vsync_in = 1'b0;
        tick(2);
        vsync_in = 1'b1;
        tick(3);
        chk("rst_mid_pre", 16'(n_int), 16'h0);
        reset    = 1'b1;
        vsync_in = 1'b0;
        #1;
        chk("rst_mid_nint", 16'(n_int), 16'h1);
        chk("rst_mid_ula", 16'({border, mic, beeper}), 16'h0);
        chk("rst_mid_page", 16'({ram_page, scr_sel, rom_sel, pg_lock}), 16'h0);

        // strobe held through reset release
        a      = 16'h00FE;
        d_in   = 8'h07;
        n_iorq = 1'b0;
        n_wr   = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("inflight_hold", 16'(border), 16'h0);
        n_iorq = 1'b1;
        n_wr   = 1'b1;
        tick(2);
        chk("inflight_release", 16'({border, mic, beeper}), 16'h0);

        io_write(16'h00FE, 8'h05, 2);
        chk("post_rst_write", 16'(border), 16'h5);
`ifdef ZX_PAGING_EN
        io_write(16'h7FFD, 8'h03, 2);
        chk("pg_unlocked", 16'({ram_page, pg_lock}), 16'({3'd3, 1'b0}));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
